// File: rtl/adc_pkg.sv
// Shared types and default constants for the serial ADC reader.
// The optional leading-bit check in adc_serial_reader is enabled with ADC_LEAD_CHECK_EN.
package adc_pkg;

  localparam int unsigned DefDataW    = 12;
  localparam int unsigned DefLeadBits = 4;
  localparam int unsigned DefClkDiv   = 4;
  localparam int unsigned DefQuietCyc = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StQuiet
  } state_e;

  // Total bits clocked out of the ADC per conversion frame.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned lead_bits);
    return data_w + lead_bits;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin input.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_serial_reader.sv
// Frame initiator and capture for an AD7476-class 3-wire serial ADC (clk_50 domain).
// Define ADC_LEAD_CHECK_EN to flag frames whose leading bits are not all zero.
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned LEAD_BITS = DefLeadBits,
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned QUIET_CYC = DefQuietCyc
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              lead_err,
  output logic              adc_csn,
  output logic              adc_sclk,
  input  logic              adc_dout
);

  localparam int unsigned N    = frame_bits(DATA_W, LEAD_BITS);
  localparam int unsigned BitW = $clog2(N);

`ifdef ADC_LEAD_CHECK_EN
  localparam int unsigned ShW = N;
`else
  // Leading bits fall off the top of a DATA_W-wide register unchecked.
  localparam int unsigned ShW = DATA_W;
`endif

  localparam logic [7:0]      DivLast   = 8'(CLK_DIV - 1);
  localparam logic [7:0]      QuietLast = 8'(QUIET_CYC - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(N - 1);

  logic din;

  sync_2ff #(
    .ResetVal(1'b0)
  ) u_sync_dout (
    .clk  (clk_50),
    .rst_n(rst_n),
    .d    (adc_dout),
    .q    (din)
  );

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [7:0]        quiet_q, quiet_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              last_q, last_d;
  logic              csn_q, csn_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              lead_err_q, lead_err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ShW-1:0]    shreg_q, shreg_d;
  logic              half_end;

  assign half_end = (div_q == DivLast);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    quiet_d    = quiet_q;
    bit_d      = bit_q;
    last_d     = last_q;
    csn_d      = csn_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    lead_err_d = 1'b0;
    data_d     = data_q;
    shreg_d    = shreg_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          last_d  = 1'b0;
          quiet_d = '0;
        end
      end

      StSetup: begin
        if (half_end) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = StShift;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StShift: begin
        if (!half_end) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: capture the bit the ADC presented on the previous fall.
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[ShW-2:0], din};
            if (bit_q == BitLast) begin
              last_d = 1'b1;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else if (last_q) begin
            state_d = StQuiet;
            csn_d   = 1'b1;
            valid_d = 1'b1;
            data_d  = shreg_q[DATA_W-1:0];
`ifdef ADC_LEAD_CHECK_EN
            lead_err_d = |shreg_q[N-1:DATA_W];
`else
            lead_err_d = 1'b0;
`endif
          end else begin
            sclk_d = 1'b0;
          end
        end
      end

      StQuiet: begin
        if (quiet_q == QuietLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          quiet_d = '0;
          bit_d   = '0;
          last_d  = 1'b0;
        end else begin
          quiet_d = quiet_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      quiet_q    <= '0;
      bit_q      <= '0;
      last_q     <= 1'b0;
      csn_q      <= 1'b1;
      sclk_q     <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      lead_err_q <= 1'b0;
      data_q     <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      quiet_q    <= quiet_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      csn_q      <= csn_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      lead_err_q <= lead_err_d;
      data_q     <= data_d;
      shreg_q    <= shreg_d;
    end
  end

  assign adc_csn    = csn_q;
  assign adc_sclk   = sclk_q;
  assign busy       = busy_q;
  assign data_valid = valid_q;
  assign lead_err   = lead_err_q;
  assign data       = data_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Self-checking bench: behavioural ADC models and event monitors around two reader instances.
module tb_adc_serial_reader;

  localparam int unsigned DW  = 12;
  localparam int unsigned LB  = 4;
  localparam int unsigned N   = DW + LB;
  localparam int unsigned CDA = 4;
  localparam int unsigned QCA = 8;
  localparam int unsigned CDB = 7;
  localparam int unsigned QCB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_a = 1'b0, busy_a, valid_a, lerr_a, csn_a, sclk_a, dout_a = 1'b0;
  logic [DW-1:0] data_a;
  logic          start_b = 1'b0, busy_b, valid_b, lerr_b, csn_b, sclk_b, dout_b = 1'b0;
  logic [DW-1:0] data_b;

  adc_serial_reader #(
    .DATA_W(DW), .LEAD_BITS(LB), .CLK_DIV(CDA), .QUIET_CYC(QCA)
  ) dut_a (
    .clk_50(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .data(data_a),
    .data_valid(valid_a), .lead_err(lerr_a), .adc_csn(csn_a), .adc_sclk(sclk_a),
    .adc_dout(dout_a)
  );

  adc_serial_reader #(
    .DATA_W(DW), .LEAD_BITS(LB), .CLK_DIV(CDB), .QUIET_CYC(QCB)
  ) dut_b (
    .clk_50(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .data(data_b),
    .data_valid(valid_b), .lead_err(lerr_b), .adc_csn(csn_b), .adc_sclk(sclk_b),
    .adc_dout(dout_b)
  );

  // ADC models: new frame on CS fall, next bit (MSB first) on each SCLK fall.
  logic [N-1:0] frames_a[$];
  logic [N-1:0] frames_b[$];
  logic [N-1:0] cur_a = '0, cur_b = '0;
  int           idx_a = 0, idx_b = 0;
  logic         pcsn_a = 1'b1, psclk_a = 1'b1, pcsn_b = 1'b1, psclk_b = 1'b1;

  always @(negedge clk) begin
    if (pcsn_a && !csn_a) begin
      if (frames_a.size() > 0) cur_a <= frames_a.pop_front();
      else cur_a <= '0;
      idx_a  <= 0;
      dout_a <= 1'b0;
    end else if (psclk_a && !sclk_a && !csn_a) begin
      dout_a <= (idx_a < int'(N)) ? cur_a[int'(N) - 1 - idx_a] : 1'b0;
      idx_a  <= idx_a + 1;
    end
    pcsn_a  <= csn_a;
    psclk_a <= sclk_a;
  end

  always @(negedge clk) begin
    if (pcsn_b && !csn_b) begin
      if (frames_b.size() > 0) cur_b <= frames_b.pop_front();
      else cur_b <= '0;
      idx_b  <= 0;
      dout_b <= 1'b0;
    end else if (psclk_b && !sclk_b && !csn_b) begin
      dout_b <= (idx_b < int'(N)) ? cur_b[int'(N) - 1 - idx_b] : 1'b0;
      idx_b  <= idx_b + 1;
    end
    pcsn_b  <= csn_b;
    psclk_b <= sclk_b;
  end

  // Event monitors, timestamped with the cycle in which each output change is visible.
  int            csn_fall_a[$], rise_a[$], hi_len_a[$], busy_fall_a[$], vcyc_a[$];
  logic [DW-1:0] vdata_a[$];
  logic          vlerr_a[$];
  int            stray_a = 0, last_csn_rise_a = -1;
  logic          mcsn_a = 1'b1, msclk_a = 1'b1, mbusy_a = 1'b0;

  always @(negedge clk) begin
    if (mcsn_a && !csn_a) begin
      csn_fall_a.push_back(cyc);
      if (last_csn_rise_a >= 0) hi_len_a.push_back(cyc - last_csn_rise_a);
    end
    if (!mcsn_a && csn_a) last_csn_rise_a <= cyc;
    if (!msclk_a && sclk_a && !csn_a) rise_a.push_back(cyc);
    if (mbusy_a && !busy_a) busy_fall_a.push_back(cyc);
    if (valid_a) begin
      vcyc_a.push_back(cyc);
      vdata_a.push_back(data_a);
      vlerr_a.push_back(lerr_a);
    end
    if (lerr_a && !valid_a) stray_a <= stray_a + 1;
    mcsn_a  <= csn_a;
    msclk_a <= sclk_a;
    mbusy_a <= busy_a;
  end

  int            rise_b[$], fall_b[$], busy_fall_b[$], vcyc_b[$];
  logic [DW-1:0] vdata_b[$];
  logic          msclk_b = 1'b1, mbusy_b = 1'b0;

  always @(negedge clk) begin
    if (!msclk_b && sclk_b && !csn_b) rise_b.push_back(cyc);
    if (msclk_b && !sclk_b && !csn_b) fall_b.push_back(cyc);
    if (mbusy_b && !busy_b) busy_fall_b.push_back(cyc);
    if (valid_b) begin
      vcyc_b.push_back(cyc);
      vdata_b.push_back(data_b);
    end
    msclk_b <= sclk_b;
    mbusy_b <= busy_b;
  end

  // Reference model: timing and results computed directly from the frame rules.
  function automatic int exp_rise(input int t0, input int k, input int cd);
    return t0 + 1 + 2 * k * cd;
  endfunction

  function automatic int exp_valid(input int t0, input int cd);
    return t0 + 1 + (2 * int'(N) + 1) * cd;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [N-1:0] f);
    return f[DW-1:0];
  endfunction

  function automatic logic exp_lerr(input logic [N-1:0] f);
`ifdef ADC_LEAD_CHECK_EN
    return (f[N-1:DW] != '0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle_a(input string tag);
    int b;
    b = 0;
    tick(2);
    while (busy_a && b < 2000) begin
      tick(1);
      b++;
    end
    chk(tag, (b < 2000) ? 32'd1 : 32'd0, 32'd1);
    tick(2);
  endtask

  // Launch one frame on instance A with a start pulse of 'width' cycles.
  task automatic frame_a(input logic [N-1:0] f, input int width, output int t0);
    frames_a.push_back(f);
    @(negedge clk);
    t0 = cyc;
    start_a = 1'b1;
    tick(width);
    start_a = 1'b0;
    wait_idle_a("idle_timeout_a");
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, bv, br, bf, bb, bh, bud, period, b_fb;
    logic [N-1:0] f, fr[3];

    // Reset state
    tick(3);
    chk("rst_csn", csn_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_lerr", lerr_a, 0);
    chk("rst_data", data_a, 0);
    rst_n = 1'b1;
    tick(3);

    // Single frame 0x0A5C, full timing
    bv = vcyc_a.size(); br = rise_a.size(); bf = csn_fall_a.size(); bb = busy_fall_a.size();
    frame_a(16'h0A5C, 1, t0);
    chk("t1_csn_fall", csn_fall_a[bf], t0 + 1);
    chk("t1_nrise", rise_a.size() - br, N);
    chk("t1_rise1", rise_a[br], exp_rise(t0, 1, CDA));
    chk("t1_rise16", rise_a[br + 15], exp_rise(t0, 16, CDA));
    chk("t1_nvalid", vcyc_a.size() - bv, 1);
    chk("t1_vcyc", vcyc_a[bv], exp_valid(t0, CDA));
    chk("t1_data", vdata_a[bv], exp_data(16'h0A5C));
    chk("t1_lerr", vlerr_a[bv], exp_lerr(16'h0A5C));
    chk("t1_busy_fall", busy_fall_a[bb], exp_valid(t0, CDA) + QCA);
    chk("t1_data_hold", data_a, exp_data(16'h0A5C));

    // start held high: back-to-back frames
    fr[0] = 16'h0FFF; fr[1] = 16'h0000; fr[2] = 16'h0801;
    bv = vcyc_a.size(); bf = csn_fall_a.size(); bh = hi_len_a.size();
    for (int i = 0; i < 3; i++) frames_a.push_back(fr[i]);
    @(negedge clk);
    t0 = cyc;
    start_a = 1'b1;
    bud = 0;
    while (vcyc_a.size() - bv < 3 && bud < 1000) begin
      tick(1);
      bud++;
    end
    start_a = 1'b0;
    chk("t2_budget", (bud < 1000) ? 32'd1 : 32'd0, 32'd1);
    wait_idle_a("t2_idle");
    period = (2 * int'(N) + 1) * int'(CDA) + int'(QCA) + 1;
    chk("t2_nvalid", vcyc_a.size() - bv, 3);
    chk("t2_nfall", csn_fall_a.size() - bf, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_data%0d", i), vdata_a[bv + i], exp_data(fr[i]));
      chk($sformatf("t2_fall%0d", i), csn_fall_a[bf + i], t0 + 1 + i * period);
    end
    chk("t2_gap1", hi_len_a[bh + 1], QCA + 1);
    chk("t2_gap2", hi_len_a[bh + 2], QCA + 1);

    // Randomized frames with random gaps and start widths
    for (int r = 0; r < 5; r++) begin
      f = N'($urandom);
      tick($urandom_range(0, 5));
      bv = vcyc_a.size();
      frame_a(f, $urandom_range(1, 20), t0);
      chk($sformatf("rnd%0d_nvalid", r), vcyc_a.size() - bv, 1);
      chk($sformatf("rnd%0d_vcyc", r), vcyc_a[bv], exp_valid(t0, CDA));
      chk($sformatf("rnd%0d_data", r), vdata_a[bv], exp_data(f));
      chk($sformatf("rnd%0d_lerr", r), vlerr_a[bv], exp_lerr(f));
    end

    // start high through the whole frame: exactly one frame
    bv = vcyc_a.size(); bf = csn_fall_a.size();
    frame_a(16'h0C3A, 140, t0);
    chk("t3_nfall", csn_fall_a.size() - bf, 1);
    chk("t3_nvalid", vcyc_a.size() - bv, 1);
    chk("t3_data", vdata_a[bv], exp_data(16'h0C3A));

    // Reset at the 7th SCLK rising edge
    bv = vcyc_a.size(); br = rise_a.size();
    frames_a.push_back(16'h0777);
    @(negedge clk);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    bud = 0;
    while (rise_a.size() - br < 7 && bud < 500) begin
      tick(1);
      bud++;
    end
    chk("t4_budget", (bud < 500) ? 32'd1 : 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_csn", csn_a, 1);
    chk("t4_sclk", sclk_a, 1);
    chk("t4_busy", busy_a, 0);
    chk("t4_data", data_a, 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("t4_nvalid", vcyc_a.size() - bv, 0);
    chk("t4_data_kept", data_a, 0);
    frame_a(16'h0123, 1, t0);
    chk("t4_after_data", data_a, exp_data(16'h0123));
    chk("t4_after_vcyc", vcyc_a[bv], exp_valid(t0, CDA));

    // Non-zero leading bits
    bv = vcyc_a.size();
    frame_a(16'h4321, 1, t0);
    chk("t5_data", vdata_a[bv], exp_data(16'h4321));
    chk("t5_lerr", vlerr_a[bv], exp_lerr(16'h4321));
    chk("t5_stray_lerr", stray_a, 0);

    // Instance B: CLK_DIV=7, QUIET_CYC=1
    bv = vcyc_b.size(); br = rise_b.size(); b_fb = fall_b.size(); bb = busy_fall_b.size();
    frames_b.push_back(16'h0ABC);
    @(negedge clk);
    t0 = cyc;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    bud = 0;
    while ((busy_fall_b.size() == bb) && bud < 2000) begin
      tick(1);
      bud++;
    end
    tick(2);
    chk("t6_budget", (bud < 2000) ? 32'd1 : 32'd0, 32'd1);
    chk("t6_nrise", rise_b.size() - br, N);
    chk("t6_rise2", rise_b[br + 1], exp_rise(t0, 2, CDB));
    chk("t6_low_half", rise_b[br + 1] - fall_b[b_fb + 1], CDB);
    chk("t6_high_half", fall_b[b_fb + 1] - rise_b[br], CDB);
    chk("t6_vcyc", vcyc_b[bv], exp_valid(t0, CDB));
    chk("t6_data", vdata_b[bv], exp_data(16'h0ABC));
    chk("t6_busy_fall", busy_fall_b[bb] - vcyc_b[bv], QCB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
